// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: datapath width, bubble instruction, reset PC and fetch FSM states.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. A flush loads a bubble and overrides a stall; a stall holds every field.
module if_id_reg #(
  parameter int               XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcPlus4_q, pcPlus4_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcPlus4_d = pcPlus4_q;
    valid_d   = valid_q;
    if (flush_i) begin
      instr_d   = NOP_INSTR;
      pc_d      = '0;
      pcPlus4_d = '0;
      valid_d   = 1'b0;
    end else if (!stall_i) begin
      instr_d   = instr_i;
      pc_d      = pc_i;
      pcPlus4_d = pc_plus4_i;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcPlus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcPlus4_q <= pcPlus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pcPlus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, BOOT/RUN FSM and IF/ID register.
// Optional redirect/bubble statistics counters are built when FETCH_STAT_EN is defined.
module pc_fetch_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallF,
  input  logic            StallD,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
`ifdef FETCH_STAT_EN
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     bubble_cnt,
`endif
  output logic            ValidD
);

  import riscv_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcPlus4;
  logic            runActive;
  logic            ifIdFlush;

  assign runActive = (state_q == RUN);
  assign pcPlus4   = pc_q + {{(XLEN-3){1'b0}}, 3'd4};

  // BOOT lasts exactly one clock after reset releases, then RUN until the next reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Redirect outranks a stall so a taken branch is never lost behind a hazard hold.
  always_comb begin
    pc_d = pc_q;
    if (runActive) begin
      if (PCSrc)        pc_d = PCTargetE & {{(XLEN-2){1'b1}}, 2'b00};
      else if (!StallF) pc_d = pcPlus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign PCF       = pc_q;
  assign imem_addr = pc_q;

  // During BOOT the decode stage sees a bubble, same as a flush.
  assign ifIdFlush = !runActive || PCSrc;

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (ifIdFlush),
    .stall_i    (StallD),
    .instr_i    (imem_rdata),
    .pc_i       (pc_q),
    .pc_plus4_i (pcPlus4),
    .instr_o    (InstrD),
    .pc_o       (PCD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD)
  );

`ifdef FETCH_STAT_EN
  logic [31:0] redirectCnt_q, redirectCnt_d;
  logic [31:0] bubbleCnt_q, bubbleCnt_d;
  logic        bubbleLoad;

  // In RUN the only way ValidD is loaded low is a flush.
  assign bubbleLoad = runActive && PCSrc;

  always_comb begin
    redirectCnt_d = redirectCnt_q;
    bubbleCnt_d   = bubbleCnt_q;
    if (runActive && PCSrc && (redirectCnt_q != 32'hFFFF_FFFF))
      redirectCnt_d = redirectCnt_q + 32'd1;
    if (bubbleLoad && (bubbleCnt_q != 32'hFFFF_FFFF))
      bubbleCnt_d = bubbleCnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirectCnt_q <= '0;
      bubbleCnt_q   <= '0;
    end else begin
      redirectCnt_q <= redirectCnt_d;
      bubbleCnt_q   <= bubbleCnt_d;
    end
  end

  assign redirect_cnt = redirectCnt_q;
  assign bubble_cnt   = bubbleCnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage; imem returns addr ^ 32'hA5A5_0000.
// Counter checks are compiled in when FETCH_STAT_EN is defined.
module tb_pc_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        PCSrc;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        StallD;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_STAT_EN
  logic [31:0] redirect_cnt;
  logic [31:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc      (PCSrc),
    .PCTargetE  (PCTargetE),
    .StallF     (StallF),
    .StallD     (StallD),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
`ifdef FETCH_STAT_EN
    .redirect_cnt (redirect_cnt),
    .bubble_cnt   (bubble_cnt),
`endif
    .ValidD     (ValidD)
  );

  assign imem_rdata = imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic src, input logic [31:0] tgt,
                               input logic sf, input logic sd);
    PCSrc     = src;
    PCTargetE = tgt;
    StallF    = sf;
    StallD    = sd;
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check("rst_PCF",      PCF,           32'h0);
    check("rst_InstrD",   InstrD,        NOP);
    check("rst_ValidD",   {31'b0, ValidD}, 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Edge 1: BOOT, PC holds, bubble in decode
    step();
    check("boot_PCF",     PCF,           32'h0);
    check("boot_ValidD",  {31'b0, ValidD}, 32'h0);
    step();
    check("run1_PCF",     PCF,           32'h4);
    check("run1_InstrD",  InstrD,        32'hA5A5_0000);
    check("run1_PCD",     PCD,           32'h0);
    check("run1_ValidD",  {31'b0, ValidD}, 32'h1);
    step();
    check("run2_PCF",     PCF,           32'h8);
    check("run2_PCPlus4D", PCPlus4D,     32'h8);
    step();
    step();
    check("pre_br_PCF",   PCF,           32'h10);

    // Redirect to 0x103 lands on 0x100
    applyStimulus(1'b1, 32'h103, 1'b0, 1'b0);
    step();
    check("br_PCF",       PCF,           32'h100);
    check("br_InstrD",    InstrD,        NOP);
    check("br_ValidD",    {31'b0, ValidD}, 32'h0);
    check("br_PCD",       PCD,           32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("br2_PCF",      PCF,           32'h104);
    check("br2_PCD",      PCD,           32'h100);
    check("br2_InstrD",   InstrD,        32'hA5A5_0100);

    // Steer to 0x20 then stall for three cycles
    applyStimulus(1'b1, 32'h1C, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("st_pre_PCF",   PCF,           32'h20);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_PCF",     PCF,           32'h20);
      check("st_InstrD",  InstrD,        32'hA5A5_001C);
      check("st_PCD",     PCD,           32'h1C);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("st_rel_PCF",   PCF,           32'h24);
    check("st_rel_PCD",   PCD,           32'h20);
    check("st_rel_InstrD", InstrD,       32'hA5A5_0020);

    // Flush beats stall
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1);
    step();
    check("fs_PCF",       PCF,           32'h40);
    check("fs_ValidD",    {31'b0, ValidD}, 32'h0);
    check("fs_InstrD",    InstrD,        NOP);

    // Top-of-memory wrap
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();
    check("wr_pre_PCF",   PCF,           32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("wr_PCF",       PCF,           32'h0);
    check("wr_PCD",       PCD,           32'hFFFF_FFFC);
    check("wr_PCPlus4D",  PCPlus4D,      32'h0);
    check("wr_InstrD",    InstrD,        32'h5A5A_FFFC);
    check("wr_ValidD",    {31'b0, ValidD}, 32'h1);

    // StallF without StallD re-captures the same PC
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("dup1_PCF",     PCF,           32'h0);
    check("dup1_PCD",     PCD,           32'h0);
    check("dup1_PCPlus4D", PCPlus4D,     32'h4);
    step();
    check("dup2_PCD",     PCD,           32'h0);
    check("dup2_InstrD",  InstrD,        32'hA5A5_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("dup_rel_PCF",  PCF,           32'h4);

    // Fifth redirect, then async reset mid-cycle
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("r5_PCF",       PCF,           32'h204);
`ifdef FETCH_STAT_EN
    check("cnt_redirect", redirect_cnt,  32'd5);
    check("cnt_bubble",   bubble_cnt,    32'd5);
`endif
    #2 rst = 1'b1;
    #1;
    check("ar_PCF",       PCF,           32'h0);
    check("ar_InstrD",    InstrD,        NOP);
    check("ar_PCD",       PCD,           32'h0);
    check("ar_PCPlus4D",  PCPlus4D,      32'h0);
    check("ar_ValidD",    {31'b0, ValidD}, 32'h0);
`ifdef FETCH_STAT_EN
    check("ar_redirect",  redirect_cnt,  32'd0);
    check("ar_bubble",    bubble_cnt,    32'd0);
`endif
    step();
    rst = 1'b0;
    step();
    check("ar_boot_PCF",  PCF,           32'h0);
    check("ar_boot_ValidD", {31'b0, ValidD}, 32'h0);
    step();
    check("ar_run_PCF",   PCF,           32'h4);
    check("ar_run_InstrD", InstrD,       32'hA5A5_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
